// File: rtl/charge_pkg.sv
// Shared definitions for the charge-session controller: state encoding,
// default parameter values and derived widths.
package charge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SET     = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_CHARGE  = 2'd3
    } state_t;

    localparam int DEF_TICKS_PER_UNIT = 50;
    localparam int DEF_RATE           = 2;
    localparam int DEF_MAX_MONEY      = 20;
    localparam int DEF_TIMEOUT_CYCLES = 500;

    // Width of the binary remaining-time register at the default settings.
    localparam int TIME_W = $clog2(DEF_MAX_MONEY * DEF_RATE + 1);

    // Width of the binary input to the two-digit BCD converter (0..99).
    localparam int BCD_IN_W = 7;

endpackage

// File: rtl/charge_ctrl_bin2bcd2.sv
// Combinational conversion of a binary value 0..99 into two BCD digits.
module bin2bcd2
    import charge_pkg::*;
(
    input  logic [BCD_IN_W-1:0] value,
    output logic [3:0]          tens,
    output logic [3:0]          ones
);

    logic [3:0] tens_s;
    logic [3:0] ones_s;

    // Tens digit by threshold ladder; ones digit is the remainder, which
    // fits in four bits so the subtraction can be done modulo 16.
    always_comb begin
        tens_s = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (value >= BCD_IN_W'(10 * i)) begin
                tens_s = 4'(i);
            end else begin
                tens_s = tens_s;
            end
        end
        ones_s = value[3:0] - (tens_s * 4'd10);
    end

    assign tens = tens_s;
    assign ones = ones_s;

endmodule

// File: rtl/charge_ctrl.sv
// Charge-session controller: money entry, confirmation, charge-time
// computation and countdown, driven by single-cycle keypad events.
module charge_ctrl
    import charge_pkg::*;
#(
    parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter int RATE           = DEF_RATE,
    parameter int MAX_MONEY      = DEF_MAX_MONEY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       startSet,
    input  logic [4:0] num,
    input  logic       start,
    input  logic       clear,
    input  logic       enter,
    output logic [3:0] money_tens,
    output logic [3:0] money_ones,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       charging,
    output logic       done,
    output logic [1:0] state
);

    localparam int MONEY_W = $clog2(MAX_MONEY + 1);
    localparam int T_W     = $clog2(MAX_MONEY * RATE + 1);
    localparam int TICK_W  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t              state_r;
    logic [MONEY_W-1:0]  money_r;
    logic [T_W-1:0]      time_r;
    logic [TICK_W-1:0]   tick_r;
    logic [IDLE_W-1:0]   idle_r;
    logic                charging_r;
    logic                done_r;

    logic                any_event_s;
    logic [7:0]          money_mod_s;
    logic [7:0]          digit_sum_s;
    logic [MONEY_W-1:0]  money_digit_s;
    logic [T_W-1:0]      time_set_s;

    assign any_event_s = clear | enter | start | num[4] | startSet;
    assign time_set_s  = T_W'(money_r * RATE);

    // Next money value for a digit key: keep the last two typed digits,
    // saturating at the maximum accepted amount.
    always_comb begin
        money_mod_s = 8'(money_r) % 8'd10;
        digit_sum_s = (money_mod_s * 8'd10) + {4'd0, num[3:0]};
        if (digit_sum_s > 8'(MAX_MONEY)) begin
            money_digit_s = MONEY_W'(MAX_MONEY);
        end else begin
            money_digit_s = MONEY_W'(digit_sum_s);
        end
    end

    // Session FSM with tick and idle counters; all outputs are registered.
    // Within each state the if-chain order implements the event priority
    // clear > enter > start > digit > startSet.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            money_r    <= '0;
            time_r     <= '0;
            tick_r     <= '0;
            idle_r     <= '0;
            charging_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tick_r     <= '0;
                    idle_r     <= '0;
                    charging_r <= 1'b0;
                    if (startSet && !clear && !enter && !start && !num[4]) begin
                        state_r <= ST_SET;
                        money_r <= '0;
                    end
                end
                ST_SET: begin
                    if (any_event_s) begin
                        idle_r <= '0;
                        if (clear) begin
                            money_r <= '0;
                        end else if (enter) begin
                            if (money_r != '0) begin
                                time_r  <= time_set_s;
                                state_r <= ST_CONFIRM;
                            end
                        end else if (start) begin
                            money_r <= money_r;
                        end else if (num[4]) begin
                            money_r <= money_digit_s;
                        end
                    end else if (idle_r == IDLE_LAST) begin
                        state_r <= ST_IDLE;
                        money_r <= '0;
                        time_r  <= '0;
                        idle_r  <= '0;
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (any_event_s) begin
                        idle_r <= '0;
                        if (clear) begin
                            state_r <= ST_SET;
                            money_r <= '0;
                            time_r  <= '0;
                        end else if (enter) begin
                            state_r <= ST_CONFIRM;
                        end else if (start) begin
                            state_r    <= ST_CHARGE;
                            charging_r <= 1'b1;
                            tick_r     <= '0;
                        end
                    end else if (idle_r == IDLE_LAST) begin
                        state_r <= ST_IDLE;
                        money_r <= '0;
                        time_r  <= '0;
                        idle_r  <= '0;
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                end
                ST_CHARGE: begin
                    idle_r <= '0;
                    if (clear) begin
                        state_r    <= ST_IDLE;
                        money_r    <= '0;
                        time_r     <= '0;
                        tick_r     <= '0;
                        charging_r <= 1'b0;
                    end else if (tick_r == TICK_LAST) begin
                        tick_r <= '0;
                        if (time_r <= T_W'(1)) begin
                            done_r     <= 1'b1;
                            state_r    <= ST_IDLE;
                            money_r    <= '0;
                            time_r     <= '0;
                            charging_r <= 1'b0;
                        end else begin
                            time_r <= time_r - T_W'(1);
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    money_r    <= '0;
                    time_r     <= '0;
                    tick_r     <= '0;
                    idle_r     <= '0;
                    charging_r <= 1'b0;
                end
            endcase
        end
    end

    bin2bcd2 u_money_bcd (
        .value (BCD_IN_W'(money_r)),
        .tens  (money_tens),
        .ones  (money_ones)
    );

    bin2bcd2 u_time_bcd (
        .value (BCD_IN_W'(time_r)),
        .tens  (time_tens),
        .ones  (time_ones)
    );

    assign state    = state_r;
    assign charging = charging_r;
    assign done     = done_r;

endmodule

// File: tb/tb_charge_ctrl.sv
// Directed self-checking bench for charge_ctrl at default parameters.
module tb_charge_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       startSet = 1'b0;
    logic [4:0] num = 5'd0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       enter = 1'b0;
    logic [3:0] money_tens, money_ones, time_tens, time_ones;
    logic       charging, done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    charge_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .startSet   (startSet),
        .num        (num),
        .start      (start),
        .clear      (clear),
        .enter      (enter),
        .money_tens (money_tens),
        .money_ones (money_ones),
        .time_tens  (time_tens),
        .time_ones  (time_ones),
        .charging   (charging),
        .done       (done),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int mt, input int mo, input int tt, input int to);
        chk({tag, "_money_tens"}, 32'(money_tens), mt);
        chk({tag, "_money_ones"}, 32'(money_ones), mo);
        chk({tag, "_time_tens"},  32'(time_tens),  tt);
        chk({tag, "_time_ones"},  32'(time_ones),  to);
    endtask

    // Apply one cycle of events at a falling edge; returns at the next falling edge.
    task automatic press(input logic s_set, input logic dv, input logic [3:0] d,
                         input logic st, input logic cl, input logic en);
        startSet = s_set;
        num      = {dv, d};
        start    = st;
        clear    = cl;
        enter    = en;
        @(negedge CLK);
        startSet = 1'b0;
        num      = 5'd0;
        start    = 1'b0;
        clear    = 1'b0;
        enter    = 1'b0;
    endtask

    task automatic key_set();             press(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic key_digit(input logic [3:0] d); press(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic key_start();           press(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic key_clear();           press(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic key_enter();           press(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Wait a bounded number of cycles for done; expect exactly one pulse at exp_cyc.
    task automatic wait_done(input string tag, input int exp_cyc);
        int first  = 0;
        int pulses = 0;
        for (int k = 1; k <= exp_cyc + 4; k++) begin
            @(negedge CLK);
            if (done) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    chk({tag, "_state"}, 32'(state), 32'd0);
                    chk({tag, "_charging"}, 32'(charging), 32'd0);
                    chk_disp(tag, 0, 0, 0, 0);
                end
            end
        end
        chk({tag, "_done_cycle"}, first, exp_cyc);
        chk({tag, "_done_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int dcount;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_charging", 32'(charging), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_disp("rst", 0, 0, 0, 0);
        RST = 1'b0;
        @(negedge CLK);

        // IDLE ignores digits; digit outranks startSet
        key_digit(4'd5);
        chk("idle_digit_state", 32'(state), 32'd0);
        chk_disp("idle_digit", 0, 0, 0, 0);
        press(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("idle_prio_state", 32'(state), 32'd0);

        // Entry of 15 yuan and confirmation
        key_set();
        chk("set_state", 32'(state), 32'd1);
        key_digit(4'd1);
        chk_disp("d1", 0, 1, 0, 0);
        key_digit(4'd5);
        chk_disp("d15", 1, 5, 0, 0);
        key_enter();
        chk("confirm_state", 32'(state), 32'd2);
        chk_disp("confirm", 1, 5, 3, 0);

        // Full 30-unit countdown
        key_start();
        chk("charge_state", 32'(state), 32'd3);
        chk("charge_on", 32'(charging), 32'd1);
        idle_cycles(49);
        chk_disp("t49", 1, 5, 3, 0);
        idle_cycles(1);
        chk_disp("t50", 1, 5, 2, 9);
        wait_done("run30", 1450);
        chk("after_done", 32'(done), 32'd0);

        // Saturation, clear, enter with zero money, last-two-digit rule
        key_set();
        key_digit(4'd9);
        chk_disp("d9", 0, 9, 0, 0);
        key_digit(4'd9);
        chk_disp("sat", 2, 0, 0, 0);
        key_clear();
        chk_disp("clr", 0, 0, 0, 0);
        chk("clr_state", 32'(state), 32'd1);
        key_enter();
        chk("enter0_state", 32'(state), 32'd1);
        key_digit(4'd2);
        key_digit(4'd0);
        chk_disp("d20", 2, 0, 0, 0);
        key_digit(4'd1);
        chk_disp("d201", 0, 1, 0, 0);
        key_enter();
        chk_disp("conf1", 0, 1, 0, 2);

        // clear outranks start in CONFIRM
        press(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("cs_state", 32'(state), 32'd1);
        chk("cs_charging", 32'(charging), 32'd0);
        chk_disp("cs", 0, 0, 0, 0);

        // enter outranks digit in SET
        key_digit(4'd3);
        press(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
        chk("ed_state", 32'(state), 32'd2);
        chk_disp("ed", 0, 3, 0, 6);
        key_clear();
        chk("back_set", 32'(state), 32'd1);

        // SET timeout after 500 cycles without events
        idle_cycles(499);
        chk("to499_state", 32'(state), 32'd1);
        idle_cycles(1);
        chk("to500_state", 32'(state), 32'd0);
        chk_disp("to", 0, 0, 0, 0);

        // Abort a 10-unit charge with clear at cycle 200
        key_set();
        key_digit(4'd5);
        key_enter();
        chk_disp("conf5", 0, 5, 1, 0);
        key_start();
        dcount = 0;
        for (int k = 1; k <= 199; k++) begin
            @(negedge CLK);
            if (done) dcount++;
        end
        key_clear();
        if (done) dcount++;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_charging", 32'(charging), 32'd0);
        chk("abort_done", 32'(dcount), 32'd0);
        chk_disp("abort", 0, 0, 0, 0);

        // Reset mid-countdown overrides a simultaneous event
        key_set();
        key_digit(4'd2);
        key_enter();
        key_start();
        idle_cycles(70);
        chk_disp("mid", 0, 2, 0, 3);
        RST = 1'b1;
        startSet = 1'b1;
        @(negedge CLK);
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_charging", 32'(charging), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);
        chk_disp("rst2", 0, 0, 0, 0);
        RST = 1'b0;
        startSet = 1'b0;
        @(negedge CLK);
        chk("rst2_hold", 32'(state), 32'd0);

        // Short charge after reset: 1 yuan -> 2 units -> 100 cycles
        key_set();
        key_digit(4'd1);
        key_enter();
        key_start();
        wait_done("run2", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/charge_ctrl.md
# charge_ctrl

Charge-session controller that sits directly downstream of the keypad matrix scanner. It consumes the debounced single-cycle key events (`startSet`, digit via `num`, `start`, `clear`, `enter`) and runs the session. The session covers money entry, confirmation, charge-time computation and the countdown. It drives the charging enable and the BCD digits shown on the display.

## Interface

Parameters:
- `TICKS_PER_UNIT`, 50: CLK cycles per charge-time unit (minute). Small default for simulation.
- `RATE`, 2: charge-time units per yuan.
- `MAX_MONEY`, 20: maximum accepted amount in yuan.
- `TIMEOUT_CYCLES`, 500: CLK cycles without a key event before SET or CONFIRM aborts to IDLE.

Ports:
- `CLK` in 1: system clock. One clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `startSet` in 1: one-cycle pulse that opens a session.
- `num` in 5: `num[4]` is a one-cycle digit-valid pulse; `num[3:0]` is the digit, 0–9.
- `start` in 1: one-cycle pulse that begins charging.
- `clear` in 1: one-cycle pulse that clears or aborts.
- `enter` in 1: one-cycle pulse that confirms the amount.
- `money_tens`, `money_ones` out 4 each: BCD amount.
- `time_tens`, `time_ones` out 4 each: BCD remaining time.
- `charging` out 1: charger enable, high only in CHARGE.
- `done` out 1: one-cycle pulse when a countdown reaches zero.
- `state` out 2: IDLE=0, SET=1, CONFIRM=2, CHARGE=3.

## Operation

- State is held in a 2-bit state register. `money` is binary, 0..MAX_MONEY. `time` is binary, 0..MAX_MONEY*RATE, and is 6 bits at the defaults.
- Event priority when several events arrive in one cycle: `clear` > `enter` > `start` > digit > `startSet`. Only the highest-priority event is acted on.
- IDLE:
  - Outputs are zero.
  - `startSet` moves to SET with money=0.
  - All other events are ignored.
- SET:
  - Digit: money = (money mod 10)*10 + digit, which keeps the last two digits. A result above MAX_MONEY saturates to MAX_MONEY.
  - `clear` sets money=0 and stays in SET.
  - `enter` with money=0 is ignored. With money>0, it sets time = money*RATE and moves to CONFIRM.
  - `start` and `startSet` are ignored.
- CONFIRM:
  - `start` moves to CHARGE.
  - `clear` moves to SET with money=0 and time=0.
  - Digits, `enter` and `startSet` are ignored.
- CHARGE:
  - `charging`=1.
  - The tick counter counts 0..TICKS_PER_UNIT-1; on wrap, time decrements.
  - When time decrements from 1 to 0: `done` pulses, the block goes to IDLE, and money is cleared.
  - `clear` aborts to IDLE with money and time cleared and no `done` pulse.
  - All other events are ignored.
- Timeout:
  - In SET and CONFIRM, an idle counter is cleared by every accepted or ignored key event.
  - When it reaches TIMEOUT_CYCLES-1, the block goes to IDLE and clears money and time.
  - The idle counter is held at zero in IDLE and CHARGE.
- A long key press is delivered upstream as one pulse. This block acts once per pulse and never on input levels.

## Timing

- All outputs are registered. An event sampled at edge N is reflected in `state`, `money_*`, `time_*` and `charging` after edge N.
- BCD outputs are combinational from the registered binary values, so they add no latency.
- The charge duration from `start` to `done` is exactly time*TICKS_PER_UNIT cycles, ±0. The tick counter is zeroed on entry to CHARGE.
- `done` is high for exactly one cycle, in the same cycle that `state` returns to IDLE.
- Reset values:
  - state=IDLE; money=0; time=0.
  - Tick and idle counters = 0.
  - `charging`=0; `done`=0.
  - All BCD outputs = 0.
- `RST` asserted in any state, including mid-countdown, takes effect at the next edge and overrides all events.

## Structure

- A shared package `charge_pkg` holds:
  - the state encoding constants (IDLE/SET/CONFIRM/CHARGE);
  - the default parameter values;
  - the width constant for time, clog2(MAX_MONEY*RATE+1).
- One sub-module, `bin2bcd2`: combinational conversion of 0..99 to tens/ones. It is instantiated twice, once for money and once for time.
- Two counters (tick, idle) and the FSM live in `charge_ctrl`.

## Test plan

- Reset, then `startSet`, then digits 1 and 5, then `enter` → state=CONFIRM, money 1/5, time 3/0.
- Continuing, `start` → `charging`=1. After 30*50=1500 cycles, `done` is a single pulse, state=IDLE, all digits 0, `charging`=0.
- In SET, digits 9 then 9 → money saturates to 2/0. Then `clear` → 0/0. Then `enter` with money=0 → state stays SET.
- In CONFIRM, pulse `clear` and `start` in the same cycle → state=SET, money 0/0, `charging` stays 0.
- In SET, no key events for 500 cycles → state=IDLE at cycle 500. In CHARGE with time=10, `clear` at cycle 200 → IDLE, no `done`. `RST` mid-countdown → all reset values next edge.
